// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the fully-connected CNN classifier slice:
//   - default parameter values (data width, image length, class count)
//   - the controller state encoding
//   - calc_acc_w(): accumulator width that cannot overflow for a full image
//     (2*DATA_W for the product, log2(IMG_LEN) for the sum, 2 spare bits for bias)
package cnn_pkg;

  localparam int DEF_DATA_W    = 15;
  localparam int DEF_IMG_LEN   = 64;
  localparam int DEF_NUM_CLASS = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    READY    = 3'd2,
    LOAD_IMG = 3'd3,
    BIAS     = 3'd4,
    ARGMAX   = 3'd5,
    OUT      = 3'd6
  } cnn_state_e;

  function automatic int calc_acc_w(input int data_w, input int img_len);
    return 2 * data_w + $clog2(img_len) + 2;
  endfunction

endpackage

// File: rtl/cnn_weight_bank.sv
// cnn_weight_bank
// Weight and bias storage for the classifier. Words are written one at a time
// by linear index in stream order: NUM_CLASS*IMG_LEN class-major weights
// followed by NUM_CLASS biases. Storage has no reset; contents are only
// meaningful after a complete reload.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_idx   - linear word index of the write
//   wr_data  - signed word to store
//   rd_pix   - pixel index to read
//   rd_w     - weight of every class for pixel rd_pix (combinational)
//   rd_b     - bias of every class (combinational)
module cnn_weight_bank
  import cnn_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_LEN   = DEF_IMG_LEN,
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int ADDR_W    = 8,
  parameter int PIX_W     = 6
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_idx,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [PIX_W-1:0]         rd_pix,
  output logic signed [DATA_W-1:0] rd_w [NUM_CLASS],
  output logic signed [DATA_W-1:0] rd_b [NUM_CLASS]
);

  localparam int TOTAL = NUM_CLASS * (IMG_LEN + 1);

  logic signed [DATA_W-1:0] mem [TOTAL];

  // Single write port; storage is intentionally kept out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Parallel read: class c weights start at c*IMG_LEN, biases follow all weights
  for (genvar c = 0; c < NUM_CLASS; c++) begin : g_rd
    localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(c * IMG_LEN);
    localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(NUM_CLASS * IMG_LEN + c);
    assign rd_w[c] = mem[W_BASE + ADDR_W'(rd_pix)];
    assign rd_b[c] = mem[B_ADDR];
  end

endmodule

// File: rtl/cnn_fc_classifier.sv
// cnn_fc_classifier
// Single fully-connected layer with argmax. A weight stream (in_valid_1)
// loads NUM_CLASS*IMG_LEN weights then NUM_CLASS biases; an image stream
// (in_valid_2) is then multiplied against all classes in parallel, biases
// are added, and the winning class is reported for one cycle.
// Optional feature macro: CNN_FC_SCORE_OUT_EN adds max_score output.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid_1    - weight-stream word valid
//   in_valid_2    - image-stream pixel valid
//   in_data       - signed data shared by both streams
//   out_valid     - one-cycle result strobe
//   class_onehot  - one-hot winning class (0 outside out_valid)
//   class_idx     - binary winning class (0 outside out_valid)
//   seq_err       - one-cycle pulse per out-of-sequence stream word
//   max_score     - winning score during out_valid (CNN_FC_SCORE_OUT_EN only)
module cnn_fc_classifier
  import cnn_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IMG_LEN   = DEF_IMG_LEN,
  parameter int NUM_CLASS = DEF_NUM_CLASS,
  parameter int ACC_W     = calc_acc_w(DATA_W, IMG_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid_1,
  input  logic                         in_valid_2,
  input  logic signed [DATA_W-1:0]     in_data,
  output logic                         out_valid,
  output logic [NUM_CLASS-1:0]         class_onehot,
  output logic [$clog2(NUM_CLASS)-1:0] class_idx,
  output logic                         seq_err
`ifdef CNN_FC_SCORE_OUT_EN
  ,
  output logic signed [ACC_W-1:0]      max_score
`endif
);

  localparam int TOTAL_W = NUM_CLASS * (IMG_LEN + 1);
  localparam int ADDR_W  = $clog2(TOTAL_W);
  localparam int PIX_W   = (IMG_LEN > 1) ? $clog2(IMG_LEN) : 1;
  localparam int CIDX_W  = $clog2(NUM_CLASS);
  localparam logic [ADDR_W-1:0]    LAST_W   = ADDR_W'(TOTAL_W - 1);
  localparam logic [PIX_W-1:0]     LAST_PIX = PIX_W'(IMG_LEN - 1);
  localparam logic [CIDX_W-1:0]    LAST_C   = CIDX_W'(NUM_CLASS - 1);
  localparam logic [NUM_CLASS-1:0] OH_ONE   = NUM_CLASS'(1'b1);

  cnn_state_e state;
  logic [ADDR_W-1:0]        wcnt;
  logic [PIX_W-1:0]         pcnt;
  logic [CIDX_W-1:0]        scan;
  logic signed [ACC_W-1:0]  acc [NUM_CLASS];
  logic signed [ACC_W-1:0]  best;
  logic [CIDX_W-1:0]        best_idx;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_idx;
  logic [PIX_W-1:0]         rd_pix;
  logic signed [DATA_W-1:0] rd_w [NUM_CLASS];
  logic signed [DATA_W-1:0] rd_b [NUM_CLASS];
  logic signed [ACC_W-1:0]  pix_ext;
  logic signed [ACC_W-1:0]  acc_mac [NUM_CLASS];
  logic signed [ACC_W-1:0]  acc_bias [NUM_CLASS];

  cnn_weight_bank #(
    .DATA_W    (DATA_W),
    .IMG_LEN   (IMG_LEN),
    .NUM_CLASS (NUM_CLASS),
    .ADDR_W    (ADDR_W),
    .PIX_W     (PIX_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (in_data),
    .rd_pix  (rd_pix),
    .rd_w    (rd_w),
    .rd_b    (rd_b)
  );

  // Weight write decode, read address, and per-class MAC / bias-add datapath
  always_comb begin
    wr_en  = in_valid_1 && (state == IDLE || state == READY || state == LOAD_W);
    // The first word of a reload is accepted outside LOAD_W and is always word 0
    wr_idx = (state == LOAD_W) ? wcnt : {ADDR_W{1'b0}};
    // The first pixel of an image arrives while still in READY
    rd_pix = (state == READY) ? {PIX_W{1'b0}} : pcnt;
    pix_ext = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    for (int c = 0; c < NUM_CLASS; c++) begin
      // Operands are sign-extended to ACC_W so the truncated product is exact
      acc_mac[c] = ((state == READY) ? {ACC_W{1'b0}} : acc[c])
                 + ({{(ACC_W-DATA_W){rd_w[c][DATA_W-1]}}, rd_w[c]} * pix_ext);
      acc_bias[c] = acc[c] + {{(ACC_W-DATA_W){rd_b[c][DATA_W-1]}}, rd_b[c]};
    end
  end

  // Controller FSM, counters, accumulators, argmax tracker and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wcnt         <= {ADDR_W{1'b0}};
      pcnt         <= {PIX_W{1'b0}};
      scan         <= {CIDX_W{1'b0}};
      best         <= {ACC_W{1'b0}};
      best_idx     <= {CIDX_W{1'b0}};
      out_valid    <= 1'b0;
      class_onehot <= {NUM_CLASS{1'b0}};
      class_idx    <= {CIDX_W{1'b0}};
      seq_err      <= 1'b0;
`ifdef CNN_FC_SCORE_OUT_EN
      max_score    <= {ACC_W{1'b0}};
`endif
      for (int c = 0; c < NUM_CLASS; c++) begin
        acc[c] <= {ACC_W{1'b0}};
      end
    end else begin
      out_valid    <= 1'b0;
      class_onehot <= {NUM_CLASS{1'b0}};
      class_idx    <= {CIDX_W{1'b0}};
      seq_err      <= 1'b0;
`ifdef CNN_FC_SCORE_OUT_EN
      max_score    <= {ACC_W{1'b0}};
`endif
      case (state)
        IDLE: begin
          seq_err <= in_valid_2;
          if (in_valid_1) begin
            state <= LOAD_W;
            wcnt  <= ADDR_W'(1'b1);
          end
        end
        READY: begin
          // A weight word takes priority; a simultaneous pixel is flagged
          if (in_valid_1) begin
            state   <= LOAD_W;
            wcnt    <= ADDR_W'(1'b1);
            seq_err <= in_valid_2;
          end else if (in_valid_2) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
              acc[c] <= acc_mac[c];
            end
            if (IMG_LEN == 1) begin
              state <= BIAS;
              pcnt  <= {PIX_W{1'b0}};
            end else begin
              state <= LOAD_IMG;
              pcnt  <= PIX_W'(1'b1);
            end
          end
        end
        LOAD_W: begin
          seq_err <= in_valid_2;
          if (in_valid_1) begin
            if (wcnt == LAST_W) begin
              state <= READY;
              wcnt  <= {ADDR_W{1'b0}};
            end else begin
              wcnt <= wcnt + ADDR_W'(1'b1);
            end
          end
        end
        LOAD_IMG: begin
          seq_err <= in_valid_1;
          if (in_valid_2) begin
            for (int c = 0; c < NUM_CLASS; c++) begin
              acc[c] <= acc_mac[c];
            end
            if (pcnt == LAST_PIX) begin
              state <= BIAS;
              pcnt  <= {PIX_W{1'b0}};
            end else begin
              pcnt <= pcnt + PIX_W'(1'b1);
            end
          end
        end
        BIAS: begin
          seq_err <= in_valid_1;
          for (int c = 0; c < NUM_CLASS; c++) begin
            acc[c] <= acc_bias[c];
          end
          state <= ARGMAX;
          scan  <= {CIDX_W{1'b0}};
        end
        ARGMAX: begin
          seq_err <= in_valid_1;
          // Class 0 seeds the tracker; strict greater keeps the lowest index on ties
          if (scan == {CIDX_W{1'b0}} || acc[scan] > best) begin
            best     <= acc[scan];
            best_idx <= scan;
          end
          if (scan == LAST_C) begin
            state <= OUT;
            scan  <= {CIDX_W{1'b0}};
          end else begin
            scan <= scan + CIDX_W'(1'b1);
          end
        end
        OUT: begin
          seq_err      <= in_valid_1;
          out_valid    <= 1'b1;
          class_onehot <= OH_ONE << best_idx;
          class_idx    <= best_idx;
`ifdef CNN_FC_SCORE_OUT_EN
          max_score    <= best;
`endif
          state        <= READY;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_fc_classifier.sv
// tb_cnn_fc_classifier
// Self-checking bench for cnn_fc_classifier at default parameters.
// A table of weight/bias/image records is loaded and run; the expected class
// (and score) for each image is pushed to a scoreboard queue when its last
// pixel is driven, and popped by a monitor when out_valid appears, which also
// checks the exact output cycle.
module tb_cnn_fc_classifier;

  localparam int DW    = 15;
  localparam int IL    = 64;
  localparam int NC    = 3;
  localparam int AW    = 2 * DW + $clog2(IL) + 2;
  localparam int TOTAL = NC * (IL + 1);

  logic          clk;
  logic          rst;
  logic          in_valid_1;
  logic          in_valid_2;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [NC-1:0] class_onehot;
  logic [1:0]    class_idx;
  logic          seq_err;
`ifdef CNN_FC_SCORE_OUT_EN
  logic [AW-1:0] max_score;
`endif

  cnn_fc_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_1   (in_valid_1),
    .in_valid_2   (in_valid_2),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .class_onehot (class_onehot),
    .class_idx    (class_idx),
    .seq_err      (seq_err)
`ifdef CNN_FC_SCORE_OUT_EN
    ,
    .max_score    (max_score)
`endif
  );

  typedef struct packed {
    bit         ramp;
    int         w0, w1, w2;
    int         b0, b1, b2;
    int         pix;
    int         gap_at;
    bit         has_exp;
    logic [2:0] exp_oh;
    int         exp_idx;
    longint     exp_score;
  } vec_t;

  typedef struct packed {
    logic [2:0] oh;
    int         idx;
    longint     score;
    int         cyc;
  } exp_t;

  vec_t   vecs [8];
  exp_t   exp_q [$];
  exp_t   mon_e;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     ov_cnt = 0;
  int     seq_cnt = 0;
  int     last_exp_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: scoreboard pop on out_valid, zero outputs otherwise
  always @(negedge clk) begin
    if (seq_err) seq_cnt++;
    if (rst) begin
      chk("out_valid_in_reset", longint'(out_valid), 0);
    end else if (out_valid) begin
      ov_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("class_onehot", longint'(class_onehot), longint'(mon_e.oh));
        chk("class_idx", longint'(class_idx), longint'(mon_e.idx));
        chk("out_cycle", longint'(cyc), longint'(mon_e.cyc));
`ifdef CNN_FC_SCORE_OUT_EN
        chk("max_score", $signed(max_score), mon_e.score);
`endif
      end
    end else begin
      chk("idle_outputs", longint'({class_onehot, class_idx}), 0);
`ifdef CNN_FC_SCORE_OUT_EN
      chk("idle_score", longint'(max_score), 0);
`endif
    end
  end

  function automatic int wgen(input vec_t v, input int c, input int k);
    if (v.ramp) return (c + 1) * (k % 11) - 5 * c - 3;
    case (c)
      0:       return v.w0;
      1:       return v.w1;
      default: return v.w2;
    endcase
  endfunction

  function automatic int bgen(input vec_t v, input int c);
    case (c)
      0:       return v.b0;
      1:       return v.b1;
      default: return v.b2;
    endcase
  endfunction

  function automatic int pgen(input vec_t v, input int k);
    return v.ramp ? (k % 7) - 3 : v.pix;
  endfunction

  // Expected result: table constants, or a reference dot-product + argmax
  function automatic exp_t model(input vec_t v);
    exp_t   e;
    longint a;
    int     bi;
    e = '0;
    if (v.has_exp) begin
      e.oh = v.exp_oh; e.idx = v.exp_idx; e.score = v.exp_score;
    end else begin
      bi = 0;
      for (int c = 0; c < NC; c++) begin
        a = bgen(v, c);
        for (int k = 0; k < IL; k++) a += longint'(wgen(v, c, k)) * longint'(pgen(v, k));
        if (c == 0 || a > e.score) begin
          e.score = a; bi = c;
        end
      end
      e.idx = bi;
      e.oh  = 3'b001 << bi;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input vec_t v, input bit both_first);
    int val;
    for (int j = 0; j < TOTAL; j++) begin
      if (j == 50) begin
        in_valid_1 = 1'b0;
        tick();
        tick();
      end
      if (j < NC * IL) val = wgen(v, j / IL, j % IL);
      else             val = bgen(v, j - NC * IL);
      in_valid_1 = 1'b1;
      in_valid_2 = both_first && (j == 0);
      in_data    = DW'(val);
      tick();
    end
    in_valid_1 = 1'b0;
    in_valid_2 = 1'b0;
    tick();
  endtask

  task automatic run_image(input vec_t v, input int npix);
    exp_t e;
    for (int k = 0; k < npix; k++) begin
      in_valid_2 = 1'b1;
      in_data    = DW'(pgen(v, k));
      if (k == IL - 1) begin
        e = model(v);
        e.cyc = cyc + 6;
        last_exp_cyc = e.cyc;
        exp_q.push_back(e);
      end
      tick();
      if (k == v.gap_at) begin
        in_valid_2 = 1'b0;
        for (int g = 0; g < 5; g++) begin
          in_valid_1 = (g == 2);
          in_data    = DW'(12345);
          tick();
        end
        in_valid_1 = 1'b0;
      end
    end
    in_valid_2 = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("result_timeout", longint'(exp_q.size()), 0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    int s;
    int o;
    //        ramp w0      w1 w2 b0  b1  b2 pix     gap has oh      idx score
    vecs[0] = '{1'b0, 1,      0, 0, 0,  0,  0, 2,      -1, 1'b1, 3'b001, 0, 128};
    vecs[1] = '{1'b0, 0,      0, 0, 5,  5,  3, 7,      -1, 1'b1, 3'b001, 0, 5};
    vecs[2] = '{1'b0, -1,     0, 0, 0,  0,  1, 3,      -1, 1'b1, 3'b100, 2, 1};
    vecs[3] = '{1'b0, 1,      0, 0, 0,  0,  0, 2,      20, 1'b1, 3'b001, 0, 128};
    vecs[4] = '{1'b0, 0,      2, 0, 0,  0,  0, 5,      -1, 1'b1, 3'b010, 1, 640};
    vecs[5] = '{1'b0, -16384, 0, 0, 0,  0,  0, -16384, -1, 1'b1, 3'b001, 0, 64'sd17179869184};
    vecs[6] = '{1'b1, 0,      0, 0, 10, -20, 30, 0,    -1, 1'b0, 3'b000, 0, 0};
    vecs[7] = '{1'b0, 0,      0, 0, -3, 4,  4, 1,      -1, 1'b1, 3'b010, 1, 4};

    rst = 1'b1; in_valid_1 = 1'b0; in_valid_2 = 1'b0; in_data = '0;
    repeat (3) tick();
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_onehot", longint'(class_onehot), 0);
    chk("rst_idx", longint'(class_idx), 0);
    chk("rst_seq_err", longint'(seq_err), 0);
    rst = 1'b0;
    tick();

    // Pixels before any weights: each one flagged, no result
    s = seq_cnt;
    o = ov_cnt;
    run_image(vecs[0], IL);
    exp_q.delete();
    tick();
    tick();
    chk("seq_err_no_weights", longint'(seq_cnt - s), 64);
    repeat (200) tick();
    chk("no_out_valid_no_weights", longint'(ov_cnt - o), 0);

    // Table-driven records (record 1 reloads with a simultaneous pixel on word 0)
    for (int i = 0; i < 8; i++) begin
      s = seq_cnt;
      load_weights(vecs[i], i == 1);
      run_image(vecs[i], IL);
      wait_done();
      chk("seq_err_vec", longint'(seq_cnt - s), (i == 1 || vecs[i].gap_at >= 0) ? 1 : 0);
    end

    // Back-to-back images: next image starts in the out_valid cycle
    run_image(vecs[7], IL);
    while (cyc < last_exp_cyc) tick();
    run_image(vecs[7], IL);
    wait_done();

    // Reset in the middle of an image, then a full reload
    load_weights(vecs[4], 1'b0);
    run_image(vecs[4], 30);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    s = seq_cnt;
    in_valid_2 = 1'b1;
    in_data    = DW'(1);
    tick();
    in_valid_2 = 1'b0;
    tick();
    tick();
    chk("seq_err_after_rst", longint'(seq_cnt - s), 1);
    load_weights(vecs[2], 1'b0);
    run_image(vecs[2], IL);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_fc_classifier.md
CNN_FC_CLASSIFIER -- requirements
Module: cnn_fc_classifier

Interface
REQ-001 SHALL have parameter DATA_W, default 15: signed width of weight, bias and pixel words.
REQ-002 SHALL have parameter IMG_LEN, default 64: pixels per image.
REQ-003 SHALL have parameter NUM_CLASS, default 3, range 2..16: number of output classes.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(IMG_LEN)+2: signed accumulator width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid_1, input, 1: weight-stream word valid.
REQ-008 SHALL have port in_valid_2, input, 1: image-stream pixel valid.
REQ-009 SHALL have port in_data, input, DATA_W: signed data shared by both streams.
REQ-010 SHALL have port out_valid, output, 1: one-cycle result strobe.
REQ-011 SHALL have port class_onehot, output, NUM_CLASS: one-hot winning class, bit c means class c.
REQ-012 SHALL have port class_idx, output, $clog2(NUM_CLASS): binary winning class.
REQ-013 SHALL have port seq_err, output, 1: one-cycle pulse on an out-of-sequence stream word.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD_W, READY, LOAD_IMG, BIAS, ARGMAX, OUT.
REQ-015 Weight stream SHALL be NUM_CLASS*IMG_LEN weights, class-major (class 0 pixels 0..IMG_LEN-1 first), then NUM_CLASS biases in class order.
REQ-016 In IDLE or READY, an in_valid_1 word SHALL enter LOAD_W, clear weights-ready, and be stored as word 0.
REQ-017 LOAD_W SHALL go to READY on the cycle after the final bias is stored; in_valid_1 low mid-load SHALL pause the count without error.
REQ-018 In READY, an in_valid_2 pixel SHALL enter LOAD_IMG, clear all NUM_CLASS accumulators, and process that pixel as pixel 0.
REQ-019 Each accepted pixel k SHALL update acc[c] += w[c][k]*pixel for all c in the same cycle, using full signed ACC_W arithmetic with no saturation.
REQ-020 in_valid_2 low mid-image SHALL hold the pixel count; processing resumes at the next valid pixel.
REQ-021 After pixel IMG_LEN-1, BIAS SHALL add bias[c] to acc[c] in one cycle.
REQ-022 ARGMAX SHALL scan classes 0..NUM_CLASS-1, one per cycle, using signed strict-greater comparison, so the lowest index wins ties.
REQ-023 out_valid SHALL be high exactly NUM_CLASS+2 cycles after the edge that samples the last pixel, for exactly one cycle; class_onehot and class_idx are valid only in that cycle and are 0 otherwise.
REQ-024 After OUT the FSM SHALL return to READY with weights retained; a pixel in the cycle after out_valid SHALL be accepted.
REQ-025 in_valid_2 in IDLE or LOAD_W, or in_valid_1 in LOAD_IMG/BIAS/ARGMAX/OUT, SHALL be ignored and SHALL pulse seq_err for one cycle per offending word.
REQ-026 Simultaneous in_valid_1 and in_valid_2 SHALL be treated as follows: in IDLE/READY in_valid_1 wins and in_valid_2 raises seq_err; in other states REQ-025 applies to the disallowed stream.

Reset
REQ-027 rst SHALL return the FSM to IDLE, clear all counters, accumulators and weights-ready, and drive out_valid, class_onehot, class_idx and seq_err to 0 on the next edge, including mid-load or mid-image.
REQ-028 Weight and bias storage SHALL NOT be cleared by reset; it is invalid until a full reload completes.

Configuration
REQ-029 With macro CNN_FC_SCORE_OUT_EN defined, the block SHALL add output port max_score, ACC_W, carrying the signed winning score during out_valid and 0 otherwise.
REQ-030 Without CNN_FC_SCORE_OUT_EN, the max_score port and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package cnn_pkg SHALL hold the FSM state enum, default parameter constants, and the ACC_W derivation function.
REQ-032 Weight/bias storage SHALL be sub-module cnn_weight_bank: write by linear index; read returns all NUM_CLASS weights of one pixel index in parallel, plus the biases.

Verification
REQ-033 Defaults; class-0 weights all 1, other weights 0, biases 0; image all 2 -> out_valid at last pixel +5 cycles, class_onehot=3'b001, class_idx=0, max_score=128.
REQ-034 All weights 0, biases 5,5,3 -> class_onehot=3'b001 (tie, lowest index wins).
REQ-035 Class-0 weights all -1, others 0; biases 0,0,1; image all 3 -> class_idx=2, max_score=1.
REQ-036 in_valid_2 for 64 pixels before any weights -> 64 seq_err pulses, no out_valid within 200 cycles.
REQ-037 Drop in_valid_2 for 5 cycles after pixel 20 -> same result as the contiguous case; out_valid at last pixel +5.
REQ-038 rst after 30 pixels, then full weight reload and image -> out_valid low throughout reset, correct result after reload.
